pwm_peripheral: RTL and testbench

//   Consumes the five SPI-written control registers and drives 16 output pins.

---
 rtl/pwm_peripheral.sv | 100 ++++++++++
 tb/tb_pwm_peripheral.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : pwm_peripheral
// Description : 16-pin output driver. Each pin is low, static high or a shared
//               8-bit PWM waveform. Optional macro PWM_SHADOW_EN makes duty
//               updates take effect only at the period boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_peripheral #(
  parameter int CLK_DIV = 3000,
  parameter int PRE_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [7:0]       pcnt;
  logic [7:0]       duty_q;
  logic             tick;
  logic             wrap;
  logic             pwm_level;
  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [15:0]      pin_next;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // ena gates the tick, so a disabled block never advances or wraps.
  assign tick = ena && (pre == PRE_MAX);
  assign wrap = tick && (pcnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre  <= '0;
      pcnt <= '0;
    end else if (ena) begin
      if (tick) begin
        pre  <= '0;
        pcnt <= pcnt + 8'd1;
      end else begin
        pre  <= pre + PRE_W'(1);
      end
    end
  end

`ifdef PWM_SHADOW_EN
  logic load_pending;

  // Duty is captured once right after reset, then only on the 255->0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q       <= 8'h00;
      load_pending <= 1'b1;
    end else if (load_pending || wrap) begin
      duty_q       <= pwm_duty_cycle;
      load_pending <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= 8'h00;
    end else begin
      duty_q <= pwm_duty_cycle;
    end
  end
`endif

  always_comb begin
    pwm_level = (duty_q == 8'hFF) ? 1'b1 : (pcnt < duty_q);
    pin_next  = (en_out & ~en_pwm) | (en_out & en_pwm & {16{pwm_level}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= 16'h0000;
      period_start <= 1'b0;
    end else if (!ena) begin
      out          <= 16'h0000;
      period_start <= 1'b0;
    end else begin
      out          <= pin_next;
      period_start <= wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// Self-checking bench for pwm_peripheral: directed scenarios plus random
// stimulus against an elapsed-cycle arithmetic reference model.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = CLK_DIV * 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [15:0] en_out = 16'h0000;
  logic [15:0] en_pwm = 16'h0000;
  logic [7:0]  duty = 8'h00;
  logic [15:0] out;
  logic        period_start;

  int total = 0;
  int bad   = 0;

  pwm_peripheral #(.CLK_DIV(CLK_DIV), .PRE_W(12)) dut (
    .clk             (clk),
    .rst             (rst),
    .ena             (ena),
    .en_reg_out_7_0  (en_out[7:0]),
    .en_reg_out_15_8 (en_out[15:8]),
    .en_reg_pwm_7_0  (en_pwm[7:0]),
    .en_reg_pwm_15_8 (en_pwm[15:8]),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  // Reference model: position in the period is derived from the number of
  // enabled cycles since reset, counted with plain integer arithmetic.
  int          en_cycles = 0;
  logic [7:0]  duty_m = 8'h00;
  bit          first_m = 1'b1;
  logic [15:0] exp_out = 16'h0000;
  logic        exp_ps = 1'b0;

  always @(posedge clk) begin
    int  pc;
    int  pr;
    bit  lvl;
    bit  wrap_m;
    if (rst) begin
      en_cycles = 0;
      duty_m    = 8'h00;
      first_m   = 1'b1;
      exp_out   = 16'h0000;
      exp_ps    = 1'b0;
    end else begin
      pc     = (en_cycles / CLK_DIV) % 256;
      pr     = en_cycles % CLK_DIV;
      lvl    = (duty_m == 8'hFF) || (pc < int'(duty_m));
      wrap_m = ena && (pr == CLK_DIV - 1) && (pc == 255);
      if (ena) begin
        exp_out = (en_out & ~en_pwm) | (en_out & en_pwm & {16{lvl}});
        exp_ps  = wrap_m;
        en_cycles = en_cycles + 1;
      end else begin
        exp_out = 16'h0000;
        exp_ps  = 1'b0;
      end
`ifdef PWM_SHADOW_EN
      if (first_m || wrap_m) duty_m = duty;
      first_m = 1'b0;
`else
      duty_m = duty;
`endif
    end
  end

  task automatic wait_ps(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (period_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int highs;
    rst = 1'b1; ena = 1'b1;
    en_out = 16'($urandom); en_pwm = 16'($urandom); duty = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out !== 16'h0000 || period_start !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: out=%h ps=%b required out=0000 ps=0", out, period_start);
      end
    end
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h01;
    rst = 1'b0;
    highs = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out[0]) highs++;
      total++;
      if (out !== exp_out) begin
        bad++;
        $display("FAIL reset_release_model: out=%h required %h", out, exp_out);
      end
    end
    total++;
    if (highs !== 3) begin
      bad++;
      $display("FAIL reset_pcnt_from_zero: highs=%0d required 3", highs);
    end
  endtask

  task automatic test_static_high();
    @(negedge clk);
    en_out = 16'hFFFF; en_pwm = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (out !== 16'hFFFF) begin
        bad++;
        $display("FAIL static_high: out=%h required FFFF", out);
      end
    end
  endtask

  task automatic test_duty_half();
    bit ok;
    int h1, h2;
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_ps(PERIOD + 10, ok);
    if (ok) wait_ps(PERIOD + 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL duty_half_timeout: period_start=0 required 1");
      return;
    end
    h1 = 0; h2 = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      if (out[0] && i <= PERIOD / 2) h1++;
      if (out[0] && i > PERIOD / 2) h2++;
    end
    total++;
    if (h1 !== 512 || h2 !== 0) begin
      bad++;
      $display("FAIL duty_half: high_first=%0d high_second=%0d required 512 0", h1, h2);
    end
    total++;
    if (period_start !== 1'b1) begin
      bad++;
      $display("FAIL period_1024: ps=%b required 1", period_start);
    end
  endtask

  task automatic test_duty_extremes();
    bit ok;
    int cnt;
    logic [7:0] dv [2];
    dv[0] = 8'h00; dv[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      duty = dv[k];
      wait_ps(PERIOD + 10, ok);
      if (ok) wait_ps(PERIOD + 10, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL extremes_timeout: period_start=0 required 1");
        return;
      end
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 3 * PERIOD; i++) begin
        @(negedge clk);
        if (out[0] !== dv[k][0]) cnt++;
      end
      total++;
      if (cnt !== 0) begin
        bad++;
        $display("FAIL duty_extreme_%h: wrong_cycles=%0d required 0", dv[k], cnt);
      end
    end
  endtask

  task automatic test_duty_change();
    bit ok;
    int cur, nxt, exp_cur;
`ifdef PWM_SHADOW_EN
    exp_cur = 256;
`else
    exp_cur = 256 + 447;
`endif
    duty = 8'h40;
    wait_ps(PERIOD + 10, ok);
    if (ok) wait_ps(PERIOD + 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL duty_change_timeout: period_start=0 required 1");
      return;
    end
    cur = 0; nxt = 0;
    for (int i = 1; i <= 2 * PERIOD; i++) begin
      @(negedge clk);
      if (out[0] && i <= PERIOD) cur++;
      if (out[0] && i > PERIOD) nxt++;
      if (i == 8'h50 * CLK_DIV) duty = 8'hC0;
    end
    total++;
    if (cur !== exp_cur) begin
      bad++;
      $display("FAIL duty_change_current: high=%0d required %0d", cur, exp_cur);
    end
    total++;
    if (nxt !== 768) begin
      bad++;
      $display("FAIL duty_change_next: high=%0d required 768", nxt);
    end
  endtask

  task automatic test_ena_freeze();
    bit ok;
    int gap;
    duty = 8'h80;
    wait_ps(PERIOD + 10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ena_timeout: period_start=0 required 1");
      return;
    end
    gap = 0;
    for (int i = 1; i <= 2 * PERIOD; i++) begin
      @(negedge clk);
      total++;
      if (out !== exp_out) begin
        bad++;
        $display("FAIL ena_model: out=%h required %h", out, exp_out);
      end
      if (i > 200 && i <= 300) begin
        total++;
        if (out !== 16'h0000 || period_start !== 1'b0) begin
          bad++;
          $display("FAIL ena_low_out: out=%h ps=%b required 0000 0", out, period_start);
        end
      end
      if (i == 200) ena = 1'b0;
      if (i == 300) ena = 1'b1;
      if (period_start === 1'b1) begin
        gap = i;
        break;
      end
    end
    total++;
    if (gap !== PERIOD + 100) begin
      bad++;
      $display("FAIL ena_freeze_gap: gap=%0d required %0d", gap, PERIOD + 100);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      total++;
      if (out !== exp_out || period_start !== exp_ps) begin
        bad++;
        $display("FAIL random_model: out=%h ps=%b required %h %b", out, period_start, exp_out, exp_ps);
      end
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) ena = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) begin
        en_out = 16'($urandom);
        en_pwm = 16'($urandom);
      end
      if ($urandom_range(0, 63) == 0) duty = 8'($urandom);
    end
    rst = 1'b0; ena = 1'b1;
  endtask

  initial begin
    test_reset();
    test_static_high();
    test_duty_half();
    test_duty_extremes();
    test_duty_change();
    test_ena_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
